// File: rtl/mc_axi_arb_pkg.sv
// mc_axi_arb_pkg: shared types and helpers for the 2-master AXI4 arbiter.
package mc_axi_arb_pkg;

    localparam int NUM_MST = 2;

    typedef logic mst_idx_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/mc_axi_arb_rr.sv
// mc_axi_arb_rr: 2-way round-robin address-channel grant FSM with registered winner.
module mc_axi_arb_rr
    import mc_axi_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               phy_init_done,
    input  logic               block,
    input  logic [NUM_MST-1:0] req,
    input  logic               hs,
    output logic               busy,
    output mst_idx_t           winner
);

    arb_state_e state, state_d;
    mst_idx_t   prio, prio_d, winner_d;
    logic       start, done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            prio   <= 1'b0;
            winner <= 1'b0;
        end else begin
            state  <= state_d;
            prio   <= prio_d;
            winner <= winner_d;
        end
    end

    // A contested grant goes to whoever holds priority; priority always moves to the loser.
    always_comb begin
        start    = (state == ARB_IDLE) && phy_init_done && !block && (|req);
        done     = (state == ARB_BUSY) && hs;
        state_d  = start ? ARB_BUSY : done ? ARB_IDLE : state;
        winner_d = start ? ((&req) ? prio : req[1]) : winner;
        prio_d   = done ? ~winner : prio;
    end

    assign busy = (state == ARB_BUSY);

endmodule

// File: rtl/mc_axi4_arb2.sv
// mc_axi4_arb2: 2-master -> 1-slave AXI4 arbiter in front of the MIG, with W ordering and ID-MSB response routing.
// Optional MC_AXI_ARB_PERF_EN adds saturating grant/stall performance counters.
module mc_axi4_arb2
    import mc_axi_arb_pkg::*;
#(
    parameter int ID_W         = 15,
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 512,
    parameter int STRB_W       = DATA_W / 8,
    parameter int W_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phy_init_done,
    input  logic [ID_W-1:0]   s0_axi_awid,
    input  logic [ADDR_W-1:0] s0_axi_awaddr,
    input  logic [7:0]        s0_axi_awlen,
    input  logic [2:0]        s0_axi_awsize,
    input  logic [1:0]        s0_axi_awburst,
    input  logic              s0_axi_awlock,
    input  logic [3:0]        s0_axi_awcache,
    input  logic [2:0]        s0_axi_awprot,
    input  logic [3:0]        s0_axi_awqos,
    input  logic              s0_axi_awvalid,
    output logic              s0_axi_awready,
    input  logic [DATA_W-1:0] s0_axi_wdata,
    input  logic [STRB_W-1:0] s0_axi_wstrb,
    input  logic              s0_axi_wlast,
    input  logic              s0_axi_wvalid,
    output logic              s0_axi_wready,
    output logic [ID_W-1:0]   s0_axi_bid,
    output logic [1:0]        s0_axi_bresp,
    output logic              s0_axi_bvalid,
    input  logic              s0_axi_bready,
    input  logic [ID_W-1:0]   s0_axi_arid,
    input  logic [ADDR_W-1:0] s0_axi_araddr,
    input  logic [7:0]        s0_axi_arlen,
    input  logic [2:0]        s0_axi_arsize,
    input  logic [1:0]        s0_axi_arburst,
    input  logic              s0_axi_arlock,
    input  logic [3:0]        s0_axi_arcache,
    input  logic [2:0]        s0_axi_arprot,
    input  logic [3:0]        s0_axi_arqos,
    input  logic              s0_axi_arvalid,
    output logic              s0_axi_arready,
    output logic [ID_W-1:0]   s0_axi_rid,
    output logic [DATA_W-1:0] s0_axi_rdata,
    output logic [1:0]        s0_axi_rresp,
    output logic              s0_axi_rlast,
    output logic              s0_axi_rvalid,
    input  logic              s0_axi_rready,
    input  logic [ID_W-1:0]   s1_axi_awid,
    input  logic [ADDR_W-1:0] s1_axi_awaddr,
    input  logic [7:0]        s1_axi_awlen,
    input  logic [2:0]        s1_axi_awsize,
    input  logic [1:0]        s1_axi_awburst,
    input  logic              s1_axi_awlock,
    input  logic [3:0]        s1_axi_awcache,
    input  logic [2:0]        s1_axi_awprot,
    input  logic [3:0]        s1_axi_awqos,
    input  logic              s1_axi_awvalid,
    output logic              s1_axi_awready,
    input  logic [DATA_W-1:0] s1_axi_wdata,
    input  logic [STRB_W-1:0] s1_axi_wstrb,
    input  logic              s1_axi_wlast,
    input  logic              s1_axi_wvalid,
    output logic              s1_axi_wready,
    output logic [ID_W-1:0]   s1_axi_bid,
    output logic [1:0]        s1_axi_bresp,
    output logic              s1_axi_bvalid,
    input  logic              s1_axi_bready,
    input  logic [ID_W-1:0]   s1_axi_arid,
    input  logic [ADDR_W-1:0] s1_axi_araddr,
    input  logic [7:0]        s1_axi_arlen,
    input  logic [2:0]        s1_axi_arsize,
    input  logic [1:0]        s1_axi_arburst,
    input  logic              s1_axi_arlock,
    input  logic [3:0]        s1_axi_arcache,
    input  logic [2:0]        s1_axi_arprot,
    input  logic [3:0]        s1_axi_arqos,
    input  logic              s1_axi_arvalid,
    output logic              s1_axi_arready,
    output logic [ID_W-1:0]   s1_axi_rid,
    output logic [DATA_W-1:0] s1_axi_rdata,
    output logic [1:0]        s1_axi_rresp,
    output logic              s1_axi_rlast,
    output logic              s1_axi_rvalid,
    input  logic              s1_axi_rready,
    output logic [ID_W:0]     m_axi_awid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awlock,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic [3:0]        m_axi_awqos,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [ID_W:0]     m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ID_W:0]     m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [ID_W:0]     m_axi_rid,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
`ifdef MC_AXI_ARB_PERF_EN
    ,
    output logic [31:0]       perf_ar_cnt0,
    output logic [31:0]       perf_ar_cnt1,
    output logic [31:0]       perf_aw_cnt0,
    output logic [31:0]       perf_aw_cnt1,
    output logic [31:0]       perf_wstall_cnt
`endif
);

    localparam int PW = $clog2(W_FIFO_DEPTH);

    logic       aw_busy, ar_busy, w_full, w_empty, w_push, w_pop;
    mst_idx_t   aw_win, ar_win, w_head;
    mst_idx_t   w_fifo [W_FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;

    mc_axi_arb_rr u_aw_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .phy_init_done (phy_init_done),
        .block         (w_full),
        .req           ({s1_axi_awvalid, s0_axi_awvalid}),
        .hs            (m_axi_awready),
        .busy          (aw_busy),
        .winner        (aw_win)
    );

    mc_axi_arb_rr u_ar_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .phy_init_done (phy_init_done),
        .block         (1'b0),
        .req           ({s1_axi_arvalid, s0_axi_arvalid}),
        .hs            (m_axi_arready),
        .busy          (ar_busy),
        .winner        (ar_win)
    );

    assign m_axi_awid     = {aw_win, aw_win ? s1_axi_awid : s0_axi_awid};
    assign m_axi_awaddr   = aw_win ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m_axi_awlen    = aw_win ? s1_axi_awlen   : s0_axi_awlen;
    assign m_axi_awsize   = aw_win ? s1_axi_awsize  : s0_axi_awsize;
    assign m_axi_awburst  = aw_win ? s1_axi_awburst : s0_axi_awburst;
    assign m_axi_awlock   = aw_win ? s1_axi_awlock  : s0_axi_awlock;
    assign m_axi_awcache  = aw_win ? s1_axi_awcache : s0_axi_awcache;
    assign m_axi_awprot   = aw_win ? s1_axi_awprot  : s0_axi_awprot;
    assign m_axi_awqos    = aw_win ? s1_axi_awqos   : s0_axi_awqos;
    assign m_axi_awvalid  = aw_busy;
    assign s0_axi_awready = aw_busy & ~aw_win & m_axi_awready;
    assign s1_axi_awready = aw_busy &  aw_win & m_axi_awready;

    assign m_axi_arid     = {ar_win, ar_win ? s1_axi_arid : s0_axi_arid};
    assign m_axi_araddr   = ar_win ? s1_axi_araddr  : s0_axi_araddr;
    assign m_axi_arlen    = ar_win ? s1_axi_arlen   : s0_axi_arlen;
    assign m_axi_arsize   = ar_win ? s1_axi_arsize  : s0_axi_arsize;
    assign m_axi_arburst  = ar_win ? s1_axi_arburst : s0_axi_arburst;
    assign m_axi_arlock   = ar_win ? s1_axi_arlock  : s0_axi_arlock;
    assign m_axi_arcache  = ar_win ? s1_axi_arcache : s0_axi_arcache;
    assign m_axi_arprot   = ar_win ? s1_axi_arprot  : s0_axi_arprot;
    assign m_axi_arqos    = ar_win ? s1_axi_arqos   : s0_axi_arqos;
    assign m_axi_arvalid  = ar_busy;
    assign s0_axi_arready = ar_busy & ~ar_win & m_axi_arready;
    assign s1_axi_arready = ar_busy &  ar_win & m_axi_arready;

    // W-order FIFO: one entry per granted AW, popped when that burst's last beat is accepted.
    assign w_empty = (wr_ptr == rd_ptr);
    assign w_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign w_head  = w_fifo[rd_ptr[PW-1:0]];
    assign w_push  = aw_busy & m_axi_awready;
    assign w_pop   = m_axi_wvalid & m_axi_wready & m_axi_wlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (w_push) wr_ptr <= wr_ptr + 1'b1;
            if (w_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) w_fifo[wr_ptr[PW-1:0]] <= aw_win;
    end

    assign m_axi_wdata   = w_head ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb   = w_head ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wlast   = w_head ? s1_axi_wlast : s0_axi_wlast;
    assign m_axi_wvalid  = ~w_empty & (w_head ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready = ~w_empty & ~w_head & m_axi_wready;
    assign s1_axi_wready = ~w_empty &  w_head & m_axi_wready;

    // Responses route on the ID bit this block prepended to the request.
    assign s0_axi_bid    = m_axi_bid[ID_W-1:0];
    assign s1_axi_bid    = m_axi_bid[ID_W-1:0];
    assign s0_axi_bresp  = m_axi_bresp;
    assign s1_axi_bresp  = m_axi_bresp;
    assign s0_axi_bvalid = m_axi_bvalid & ~m_axi_bid[ID_W];
    assign s1_axi_bvalid = m_axi_bvalid &  m_axi_bid[ID_W];
    assign m_axi_bready  = m_axi_bid[ID_W] ? s1_axi_bready : s0_axi_bready;

    assign s0_axi_rid    = m_axi_rid[ID_W-1:0];
    assign s1_axi_rid    = m_axi_rid[ID_W-1:0];
    assign s0_axi_rdata  = m_axi_rdata;
    assign s1_axi_rdata  = m_axi_rdata;
    assign s0_axi_rresp  = m_axi_rresp;
    assign s1_axi_rresp  = m_axi_rresp;
    assign s0_axi_rlast  = m_axi_rlast;
    assign s1_axi_rlast  = m_axi_rlast;
    assign s0_axi_rvalid = m_axi_rvalid & ~m_axi_rid[ID_W];
    assign s1_axi_rvalid = m_axi_rvalid &  m_axi_rid[ID_W];
    assign m_axi_rready  = m_axi_rid[ID_W] ? s1_axi_rready : s0_axi_rready;

`ifdef MC_AXI_ARB_PERF_EN
    logic ar_hs, aw_stall;

    assign ar_hs    = ar_busy & m_axi_arready;
    assign aw_stall = ~aw_busy & phy_init_done & (s0_axi_awvalid | s1_axi_awvalid) & w_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ar_cnt0    <= '0;
            perf_ar_cnt1    <= '0;
            perf_aw_cnt0    <= '0;
            perf_aw_cnt1    <= '0;
            perf_wstall_cnt <= '0;
        end else begin
            perf_ar_cnt0    <= sat_inc(perf_ar_cnt0, ar_hs & ~ar_win);
            perf_ar_cnt1    <= sat_inc(perf_ar_cnt1, ar_hs &  ar_win);
            perf_aw_cnt0    <= sat_inc(perf_aw_cnt0, w_push & ~aw_win);
            perf_aw_cnt1    <= sat_inc(perf_aw_cnt1, w_push &  aw_win);
            perf_wstall_cnt <= sat_inc(perf_wstall_cnt, aw_stall);
        end
    end
`endif

endmodule
